// File: rtl/instr_mem_stream.sv
// instr_mem_stream: loadable instruction memory with valid/ready fetch, 1-cycle registered read and out-of-range faults
module instr_mem_stream #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = '0,
  parameter bit START_RUN = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  output logic              load_err,
  input  logic              reload,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_ready,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] instruction,
  output logic              addr_fault,
  output logic              running
);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
  typedef enum logic {LOAD, RUN} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic load_ok, fetch_ok, accept, wr_en;
  always_comb begin
    load_ok = {1'b0, load_addr} < LIMIT;
    fetch_ok = {1'b0, fetch_pc} < LIMIT;
    running = state == RUN;
    fetch_ready = running && !reload && (!inst_valid || inst_ready);
    accept = fetch_valid && fetch_ready;
    wr_en = !reset && !running && load_en && load_ok;
    state_nx = running ? (reload ? LOAD : RUN) : (load_done ? RUN : LOAD);
  end
  always_ff @(posedge clock)
    state <= reset ? (START_RUN ? RUN : LOAD) : state_nx;
  always_ff @(posedge clock)
    if (wr_en) mem[load_addr[IDX_W-1:0]] <= load_data;
  always_ff @(posedge clock) begin
    if (reset) begin
      inst_valid <= 1'b0;
      instruction <= '0;
      addr_fault <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= !running && load_en && !load_ok;
      inst_valid <= accept || (inst_valid && !inst_ready && !reload);
      if (accept) begin
        instruction <= fetch_ok ? mem[fetch_pc[IDX_W-1:0]] : NOP_WORD;
        addr_fault <= !fetch_ok;
      end
    end
  end
endmodule

// File: doc/instr_mem_stream.md
Name: instr_mem_stream

Overview:
- Parametrised successor to the 8-bit nRisc instruction memory.
- Adds three things the core did not have before:
  - a program-load port, so software can be written in before execution;
  - a fetch handshake with 1-cycle registered read and stall hold;
  - out-of-range fault detection.
- Sits between the PC/fetch stage and the decode stage of the nRisc core. Replaces the toggle-signal scheme with valid/ready.

Parameters:
- DATA_W, 8, instruction word width in bits
- ADDR_W, 8, address width in bits
- DEPTH, 256, number of implemented words (DEPTH <= 2**ADDR_W)
- NOP_WORD, 0, word returned on an out-of-range fetch
- START_RUN, 0, 1 = leave reset directly in RUN (contents preloaded by initial block)

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high
- load_en  in  1  write strobe, honoured in LOAD only
- load_addr  in  ADDR_W  write address
- load_data  in  DATA_W  write data
- load_done  in  1  end of program load (LOAD->RUN)
- load_err  out  1  1-cycle pulse: load_addr >= DEPTH, write dropped
- reload  in  1  request return to LOAD (RUN->LOAD)
- fetch_valid  in  1  fetch_pc is valid
- fetch_pc  in  ADDR_W  address to fetch
- fetch_ready  out  1  fetch accepted this cycle when high with fetch_valid
- inst_valid  out  1  instruction holds valid data
- inst_ready  in  1  consumer takes instruction this cycle
- instruction  out  DATA_W  fetched word
- addr_fault  out  1  qualifies instruction: fetch_pc was >= DEPTH
- running  out  1  1 in RUN state

Behaviour:
- Clock and reset:
  - Single clock `clock`; reset is synchronous and active-high.
  - Reset forces state = (START_RUN ? RUN : LOAD) and clears inst_valid, instruction, addr_fault and load_err to 0.
  - Memory array is never cleared by reset. Reset mid-fetch discards the in-flight word.
- States: LOAD, RUN.
- LOAD state:
  - fetch_ready = 0 and inst_valid = 0.
  - load_en=1 with load_addr < DEPTH: mem[load_addr] <= load_data at that edge.
  - load_en=1 with load_addr >= DEPTH: no write; load_err = 1 the next cycle, for 1 cycle.
  - load_done=1 moves to RUN at the next edge.
  - load_en and load_done in the same cycle: the write is performed and the state moves to RUN. A fetch of that address on the first RUN cycle returns the new data.
- RUN state:
  - load_en is ignored (no write, no load_err).
  - fetch_ready = !inst_valid || inst_ready (combinational).
  - Accept = fetch_valid && fetch_ready. On accept, the next cycle has:
    - inst_valid = 1;
    - instruction = mem[fetch_pc] when fetch_pc < DEPTH, else NOP_WORD;
    - addr_fault = (fetch_pc >= DEPTH).
  - Back-to-back accepts give one word per cycle (full throughput).
  - inst_valid && !inst_ready: instruction, addr_fault and inst_valid hold stable; no new accept.
  - inst_ready && !accept: inst_valid drops to 0 next cycle. instruction and addr_fault keep their last value; it is don't-care for checking.
- reload:
  - reload=1 in RUN moves to LOAD at the next edge and clears inst_valid. Any pending word is discarded.
  - reload has priority over accept in the same cycle: no fetch is accepted.
  - reload in LOAD has no effect.
- Latency: exactly 1 cycle from accept edge to inst_valid.
- Address compare is unsigned, width ADDR_W. When DEPTH = 2**ADDR_W, addr_fault and load_err are never asserted.
- Read is synchronous (registered), so the array is inferable as block RAM.

Test Plan:
- Reset, START_RUN=0; load 19 words of fat(5) at addresses 0..18; pulse load_done. Then:
  - fetch_pc=0 -> next cycle inst_valid=1, instruction=8'b01111100, running=1.
  - fetch_pc=18 -> next cycle instruction=8'b10011100.
- Stall: fetch 1 with inst_ready=0 for 3 cycles -> instruction=8'b00000101 held and fetch_ready=0 throughout. Raise inst_ready -> accept of pc=2 in the same cycle, giving 8'b01101000 the next cycle.
- DEPTH=16, NOP_WORD=8'hFF:
  - fetch_pc=20 -> instruction=8'hFF, addr_fault=1.
  - load_addr=16 in LOAD -> load_err pulses for 1 cycle and mem is unchanged.
- Same-cycle load_en (addr 5, data 8'hA5) and load_done -> first RUN fetch of 5 returns 8'hA5. A later load_en in RUN to address 5 leaves 8'hA5.
- Mid-operation events:
  - reload asserted with inst_valid=1 and fetch_valid=1 -> next cycle LOAD, inst_valid=0, running=0, no accept.
  - reset during a fetch -> next cycle all outputs 0 and memory contents preserved.
